// File: rtl/excp_pkg.sv
// Shared definitions for the commit-side exception controller:
// exception codes, cmt_excp bit positions and controller states.
package excp_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;

    localparam int EXCP_ADEF = 0;
    localparam int EXCP_INE  = 1;
    localparam int EXCP_IPE  = 2;
    localparam int EXCP_SYS  = 3;
    localparam int EXCP_BRK  = 4;
    localparam int EXCP_ALE  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        REDIR = 2'd3
    } excp_state_e;

endpackage

// File: rtl/excp_prio_enc.sv
// Combinational arbitration of interrupt / exception flags / ERTN for one
// committing instruction. Interrupts win over everything, ERTN loses to any fault.
module excp_prio_enc
    import excp_pkg::*;
#(
    parameter int EXCP_W = 6
) (
    input  logic              has_int,
    input  logic [EXCP_W-1:0] cmt_excp,
    input  logic              cmt_ertn,
    output logic              take_excp,
    output logic              take_ertn,
    output logic [5:0]        ecode,
    output logic [8:0]        esubcode
);

    assign esubcode = '0;

    always_comb begin
        take_excp = 1'b1;
        take_ertn = 1'b0;
        ecode     = ECODE_INT;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (cmt_excp[EXCP_ADEF]) begin
            ecode = ECODE_ADEF;
        end else if (cmt_excp[EXCP_INE]) begin
            ecode = ECODE_INE;
        end else if (cmt_excp[EXCP_IPE]) begin
            ecode = ECODE_IPE;
        end else if (cmt_excp[EXCP_SYS]) begin
            ecode = ECODE_SYS;
        end else if (cmt_excp[EXCP_BRK]) begin
            ecode = ECODE_BRK;
        end else if (cmt_excp[EXCP_ALE]) begin
            ecode = ECODE_ALE;
        end else begin
            take_excp = 1'b0;
            take_ertn = cmt_ertn;
        end
    end

endmodule

// File: rtl/excp_commit_ctrl.sv
// Commit-side exception/ERTN controller: retires normal instructions, and for
// exceptions/interrupts/ERTN pulses the CSR flush, drains the pipe, then redirects fetch.
module excp_commit_ctrl
    import excp_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int EXCP_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmt_valid,
    output logic              cmt_ready,
    input  logic [31:0]       cmt_pc,
    input  logic [EXCP_W-1:0] cmt_excp,
    input  logic              cmt_ertn,
    input  logic              has_int,
    input  logic [31:0]       csr_eentry,
    input  logic [31:0]       csr_era,
    output logic              excp_flush,
    output logic              ertn_flush,
    output logic [31:0]       era_in,
    output logic [5:0]        ecode_in,
    output logic [8:0]        esubcode_in,
    output logic              pipe_flush,
    output logic              retire_valid,
    output logic [31:0]       retire_pc,
    output logic              redir_valid,
    output logic [31:0]       redir_pc,
    input  logic              redir_ready,
    output logic [31:0]       excp_cnt
);

    // Handshakes: a commit transfers on cmt_valid & cmt_ready; a redirect
    // completes on redir_valid & redir_ready, with redir_pc held stable until then.
    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    excp_state_e state;
    logic [3:0]  drain_cnt;
    logic        xfer;
    logic        take_excp;
    logic        take_ertn;
    logic [5:0]  enc_ecode;
    logic [8:0]  enc_esubcode;

    excp_prio_enc #(.EXCP_W(EXCP_W)) u_prio_enc (
        .has_int   (has_int),
        .cmt_excp  (cmt_excp),
        .cmt_ertn  (cmt_ertn),
        .take_excp (take_excp),
        .take_ertn (take_ertn),
        .ecode     (enc_ecode),
        .esubcode  (enc_esubcode)
    );

    assign cmt_ready   = (state == IDLE);
    assign xfer        = cmt_valid & cmt_ready;
    assign pipe_flush  = (state == FLUSH) || (state == DRAIN);
    assign redir_valid = (state == REDIR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            excp_flush   <= 1'b0;
            ertn_flush   <= 1'b0;
            era_in       <= '0;
            ecode_in     <= '0;
            esubcode_in  <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            redir_pc     <= '0;
            excp_cnt     <= '0;
        end else begin
            retire_valid <= 1'b0;
            excp_flush   <= 1'b0;
            ertn_flush   <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (take_excp) begin
                            state       <= FLUSH;
                            excp_flush  <= 1'b1;
                            era_in      <= cmt_pc;
                            ecode_in    <= enc_ecode;
                            esubcode_in <= enc_esubcode;
                            excp_cnt    <= excp_cnt + 32'd1;
                        end else if (take_ertn) begin
                            state      <= FLUSH;
                            ertn_flush <= 1'b1;
                        end else begin
                            retire_valid <= 1'b1;
                            retire_pc    <= cmt_pc;
                        end
                    end
                end
                FLUSH: begin
                    // The CSR presents its updated eentry/era during the flush cycle.
                    redir_pc  <= ertn_flush ? csr_era : csr_eentry;
                    drain_cnt <= DRAIN_LOAD;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= REDIR;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                REDIR: begin
                    if (redir_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Self-checking bench for excp_commit_ctrl: directed scenarios plus randomized
// commits compared against a transaction-level reference model.
module tb_excp_commit_ctrl;

    localparam int FC = 2;
    localparam int EW = 6;

    logic          clk;
    logic          reset;
    logic          cmt_valid;
    logic          cmt_ready;
    logic [31:0]   cmt_pc;
    logic [EW-1:0] cmt_excp;
    logic          cmt_ertn;
    logic          has_int;
    logic [31:0]   csr_eentry;
    logic [31:0]   csr_era;
    logic          excp_flush;
    logic          ertn_flush;
    logic [31:0]   era_in;
    logic [5:0]    ecode_in;
    logic [8:0]    esubcode_in;
    logic          pipe_flush;
    logic          retire_valid;
    logic [31:0]   retire_pc;
    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic          redir_ready;
    logic [31:0]   excp_cnt;

    excp_commit_ctrl #(.FLUSH_CYCLES(FC), .EXCP_W(EW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmt_valid    (cmt_valid),
        .cmt_ready    (cmt_ready),
        .cmt_pc       (cmt_pc),
        .cmt_excp     (cmt_excp),
        .cmt_ertn     (cmt_ertn),
        .has_int      (has_int),
        .csr_eentry   (csr_eentry),
        .csr_era      (csr_era),
        .excp_flush   (excp_flush),
        .ertn_flush   (ertn_flush),
        .era_in       (era_in),
        .ecode_in     (ecode_in),
        .esubcode_in  (esubcode_in),
        .pipe_flush   (pipe_flush),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .redir_ready  (redir_ready),
        .excp_cnt     (excp_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cnt;
    logic [31:0] last_era;
    logic [5:0]  last_ecode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference arbitration: kind 0 = retire, 1 = exception/interrupt, 2 = ERTN.
    function automatic void ref_arb(input logic intr, input logic [5:0] ex, input logic er,
                                    output int kind, output logic [5:0] code);
        logic [5:0] tbl [6];
        tbl  = '{6'h08, 6'h0D, 6'h0E, 6'h0B, 6'h0C, 6'h09};
        kind = 0;
        code = 6'h00;
        if (intr) begin
            kind = 1;
        end else begin
            for (int i = 5; i >= 0; i--) begin
                if (ex[i]) begin
                    kind = 1;
                    code = tbl[i];
                end
            end
            if (kind == 0 && er) kind = 2;
        end
    endfunction

    // driver tasks (entered and left just after a falling edge)
    task automatic wait_ready();
        int i;
        for (i = 0; i < 32 && !cmt_ready; i++) @(negedge clk);
        if (!cmt_ready) check("ready_timeout", cmt_ready, 1);
    endtask

    task automatic normal_burst(input logic [31:0] base, input int n);
        wait_ready();
        for (int i = 0; i < n; i++) begin
            cmt_valid = 1'b1;
            cmt_pc    = base + 32'(4 * i);
            cmt_excp  = '0;
            cmt_ertn  = 1'b0;
            has_int   = 1'b0;
            exp_q.push_back(cmt_pc);
            @(negedge clk);
            check("burst_retire_valid", retire_valid, 1);
            check("burst_retire_pc", retire_pc, exp_q.pop_front());
            check("burst_no_excp_flush", excp_flush, 0);
            check("burst_cmt_ready", cmt_ready, 1);
        end
        cmt_valid = 1'b0;
        @(negedge clk);
        check("burst_retire_end", retire_valid, 0);
        check("burst_no_excp_flush_end", excp_flush, 0);
    endtask

    task automatic do_cmt(input logic [31:0] pc, input logic [5:0] ex, input logic er,
                          input logic intr, input logic [31:0] eentry, input logic [31:0] era,
                          input int bp);
        int          kind;
        logic [5:0]  code;
        logic [31:0] target;
        wait_ready();
        ref_arb(intr, ex, er, kind, code);
        cmt_valid   = 1'b1;
        cmt_pc      = pc;
        cmt_excp    = ex;
        cmt_ertn    = er;
        has_int     = intr;
        csr_eentry  = eentry;
        csr_era     = era;
        redir_ready = 1'b0;
        @(negedge clk);
        cmt_valid = 1'b0;
        cmt_excp  = '0;
        cmt_ertn  = 1'b0;
        cmt_pc    = $urandom;
        has_int   = 1'($urandom_range(0, 1));
        if (kind == 0) begin
            exp_q.push_back(pc);
            check("retire_valid", retire_valid, 1);
            check("retire_pc", retire_pc, exp_q.pop_front());
            check("retire_no_flush", {29'd0, excp_flush, ertn_flush, pipe_flush}, 0);
            check("retire_era_held", era_in, last_era);
            check("retire_cmt_ready", cmt_ready, 1);
            return;
        end
        if (kind == 1) begin
            exp_cnt    = exp_cnt + 32'd1;
            last_era   = pc;
            last_ecode = code;
            target     = eentry;
        end else begin
            target = era;
        end
        check("flush_excp_flush", excp_flush, (kind == 1));
        check("flush_ertn_flush", ertn_flush, (kind == 2));
        check("flush_era_in", era_in, last_era);
        check("flush_ecode_in", ecode_in, last_ecode);
        check("flush_esubcode_in", esubcode_in, 0);
        check("flush_excp_cnt", excp_cnt, exp_cnt);
        check("flush_pipe_flush", pipe_flush, 1);
        check("flush_cmt_ready", cmt_ready, 0);
        check("flush_no_retire", retire_valid, 0);
        check("flush_no_redir", redir_valid, 0);
        for (int d = 0; d < FC; d++) begin
            @(negedge clk);
            if (d == 0) begin
                csr_eentry = $urandom;
                csr_era    = $urandom;
            end
            if (bp == 0 && d == FC - 1) redir_ready = 1'b1;
            check("drain_pipe_flush", pipe_flush, 1);
            check("drain_pulses_low", {30'd0, excp_flush, ertn_flush}, 0);
            check("drain_no_redir", redir_valid, 0);
            check("drain_cmt_ready", cmt_ready, 0);
        end
        @(negedge clk);
        for (int b = 0; b < bp; b++) begin
            check("bp_redir_valid", redir_valid, 1);
            check("bp_redir_pc", redir_pc, target);
            check("bp_pipe_flush", pipe_flush, 0);
            check("bp_cmt_ready", cmt_ready, 0);
            @(negedge clk);
        end
        redir_ready = 1'b1;
        check("redir_valid", redir_valid, 1);
        check("redir_pc", redir_pc, target);
        check("redir_pipe_flush", pipe_flush, 0);
        @(negedge clk);
        redir_ready = 1'b0;
        check("post_redir_valid", redir_valid, 0);
        check("post_cmt_ready", cmt_ready, 1);
        check("post_excp_cnt", excp_cnt, exp_cnt);
    endtask

    initial begin
        reset       = 1'b1;
        cmt_valid   = 1'b0;
        cmt_pc      = '0;
        cmt_excp    = '0;
        cmt_ertn    = 1'b0;
        has_int     = 1'b0;
        csr_eentry  = '0;
        csr_era     = '0;
        redir_ready = 1'b0;
        exp_cnt     = '0;
        last_era    = '0;
        last_ecode  = '0;
        repeat (2) @(negedge clk);
        check("rst_cmt_ready", cmt_ready, 1);
        check("rst_pulses", {29'd0, excp_flush, ertn_flush, retire_valid}, 0);
        check("rst_pipe_flush", pipe_flush, 0);
        check("rst_redir_valid", redir_valid, 0);
        check("rst_excp_cnt", excp_cnt, 0);
        check("rst_era_in", era_in, 0);
        reset = 1'b0;
        @(negedge clk);

        normal_burst(32'h1c00_0000, 3);
        do_cmt(32'h1c00_0100, 6'b001000, 1'b0, 1'b0, 32'h1c00_8000, 32'h0, 0);
        do_cmt(32'h1c00_0140, 6'b100010, 1'b1, 1'b1, 32'h1c00_8000, 32'h1c00_0999, 1);
        do_cmt(32'h1c00_0180, 6'b100010, 1'b0, 1'b0, 32'h1c00_8000, 32'h0, 0);
        do_cmt(32'h1c00_0200, 6'b000000, 1'b1, 1'b0, 32'h1c00_8000, 32'h1c00_0204, 0);
        do_cmt(32'h1c00_0300, 6'b010000, 1'b0, 1'b0, 32'h1c00_9000, 32'h0, 5);

        // reset while draining
        wait_ready();
        cmt_valid  = 1'b1;
        cmt_pc     = 32'h1c00_0400;
        cmt_excp   = 6'b000001;
        csr_eentry = 32'h1c00_a000;
        @(negedge clk);
        cmt_valid = 1'b0;
        cmt_excp  = '0;
        exp_cnt   = exp_cnt + 32'd1;
        check("rstdrain_excp_cnt", excp_cnt, exp_cnt);
        @(negedge clk);
        check("rstdrain_in_drain", pipe_flush, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt    = '0;
        last_era   = '0;
        last_ecode = '0;
        check("rstdrain_pipe_flush", pipe_flush, 0);
        check("rstdrain_redir_valid", redir_valid, 0);
        check("rstdrain_cmt_ready", cmt_ready, 1);
        check("rstdrain_excp_cnt0", excp_cnt, 0);
        check("rstdrain_no_pulse", {30'd0, excp_flush, ertn_flush}, 0);
        @(negedge clk);
        check("rstdrain_no_redir_later", redir_valid, 0);

        for (int t = 0; t < 40; t++) begin
            logic       intr;
            logic [5:0] ex;
            logic       er;
            intr = ($urandom_range(0, 5) == 0);
            ex   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            er   = ($urandom_range(0, 3) == 0);
            do_cmt({$urandom_range(0, 32'h3fff_ffff), 2'b00}, ex, er, intr,
                   $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
